// File: rtl/multicycle_core.sv
// Multicycle core: FETCH/DECODE/EXEC/MEM/WB/HALT with one instruction in flight.
// Optional cycle/instret counters are built when MULTICYCLE_CORE_PERF_EN is defined.
module multicycle_core #(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted,
    output logic [XLEN-1:0] pc_out,
`ifdef MULTICYCLE_CORE_PERF_EN
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt,
`endif
    output logic [2:0]      dbg_state
);

    localparam int              RW  = $clog2(NREGS);
    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {K_ALU, K_LD, K_SD, K_BR} kind_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT} aluop_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_mdr;
    kind_t           r_kind;
    aluop_t          r_op;
    logic            r_use_imm;
    logic            r_bne;
    logic [XLEN-1:0] r_regs [NREGS];

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [RW-1:0]   w_rs1;
    logic [RW-1:0]   w_rs2;
    logic [RW-1:0]   w_rd;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic            w_legal;
    kind_t           w_kind;
    aluop_t          w_op;
    logic            w_use_imm;
    logic            w_bne;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_opb;
    logic [XLEN-1:0] w_alu;
    logic            w_taken;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_pc_br;

    assign w_opcode  = r_ir[6:0];
    assign w_f3      = r_ir[14:12];
    assign w_f7      = r_ir[31:25];
    assign w_rs1     = r_ir[15 +: RW];
    assign w_rs2     = r_ir[20 +: RW];
    assign w_rd      = r_ir[7 +: RW];
    assign w_rs1_val = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

    // The B-format immediate is kept as imm[12:1], i.e. already in instruction units.
    assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{(XLEN-12){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8]};

    always_comb begin
        w_legal   = 1'b0;
        w_kind    = K_ALU;
        w_op      = OP_ADD;
        w_use_imm = 1'b1;
        w_bne     = 1'b0;
        w_imm     = w_imm_i;
        case (w_opcode)
            7'b0110011: begin
                w_use_imm = 1'b0;
                if (w_f7 == 7'b0000000) begin
                    w_legal = 1'b1;
                    case (w_f3)
                        3'b000:  w_op = OP_ADD;
                        3'b111:  w_op = OP_AND;
                        3'b110:  w_op = OP_OR;
                        3'b010:  w_op = OP_SLT;
                        default: w_legal = 1'b0;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_legal = 1'b1;
                    w_op    = OP_SUB;
                end
            end
            7'b0010011: begin
                w_legal = 1'b1;
                case (w_f3)
                    3'b000:  w_op = OP_ADD;
                    3'b111:  w_op = OP_AND;
                    3'b110:  w_op = OP_OR;
                    default: w_legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                w_legal = (w_f3 == 3'b011);
                w_kind  = K_LD;
            end
            7'b0100011: begin
                w_legal = (w_f3 == 3'b011);
                w_kind  = K_SD;
                w_imm   = w_imm_s;
            end
            7'b1100011: begin
                w_legal = (w_f3[2:1] == 2'b00);
                w_kind  = K_BR;
                w_bne   = w_f3[0];
                w_imm   = w_imm_b;
            end
            default: ;
        endcase
    end

    assign w_opb = r_use_imm ? r_imm : r_b;

    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD:  w_alu = r_a + w_opb;
            OP_SUB:  w_alu = r_a - w_opb;
            OP_AND:  w_alu = r_a & w_opb;
            OP_OR:   w_alu = r_a | w_opb;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_opb))};
            default: w_alu = '0;
        endcase
    end

    assign w_taken  = (r_a == r_b) ^ r_bne;
    assign w_pc_inc = r_pc + ONE;
    assign w_pc_br  = r_pc + r_imm;

    // Handshake: a request is held, with address/data stable, until ready is sampled
    // high on a rising edge; the transfer completes on that edge and ready is ignored otherwise.
    assign imem_req   = reset && (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = (r_kind == K_SD);
    assign dmem_addr  = r_alu;
    assign dmem_wdata = r_b;
    assign halted     = (r_state == S_HALT);
    assign pc_out     = r_pc;
    assign dbg_state  = r_state;

    // A store retires in the cycle its data handshake completes, hence the dmem_ready term.
    assign retire = (r_state == S_WB)
                 || (r_state == S_EXEC && r_kind == K_BR)
                 || (r_state == S_MEM && r_kind == K_SD && dmem_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_kind    <= K_ALU;
            r_op      <= OP_ADD;
            r_use_imm <= 1'b0;
            r_bne     <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_state <= S_HALT;
                    end else begin
                        r_a       <= w_rs1_val;
                        r_b       <= w_rs2_val;
                        r_imm     <= w_imm;
                        r_kind    <= w_kind;
                        r_op      <= w_op;
                        r_use_imm <= w_use_imm;
                        r_bne     <= w_bne;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    case (r_kind)
                        K_BR: begin
                            r_pc    <= w_taken ? w_pc_br : w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        K_LD, K_SD: r_state <= S_MEM;
                        default:    r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (r_kind == K_SD) begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end else begin
                            r_mdr   <= dmem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_rd != '0) r_regs[w_rd] <= (r_kind == K_LD) ? r_mdr : r_alu;
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

`ifdef MULTICYCLE_CORE_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (r_state != S_HALT) cycle_cnt <= cycle_cnt + ONE;
            if (retire) instret_cnt <= instret_cnt + ONE;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: program memories answer the core's requests,
// a monitor pops expected retire/store records from queues and compares them.
`timescale 1ns/1ps
module tb_multicycle_core;

    localparam logic [31:0] HALT_INSN = 32'h0000007f;
    localparam logic [2:0]  ST_FETCH  = 3'd0;
    localparam logic [2:0]  ST_HALT   = 3'd5;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ready;
    logic [63:0] dmem_rdata;
    logic        retire;
    logic        halted;
    logic [63:0] pc_out;
    logic [2:0]  dbg_state;
`ifdef MULTICYCLE_CORE_PERF_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
`endif

    multicycle_core #(.XLEN(64), .NREGS(32), .RESET_PC(64'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .retire     (retire),
        .halted     (halted),
        .pc_out     (pc_out),
`ifdef MULTICYCLE_CORE_PERF_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct { int cyc; logic [63:0] pc; logic [63:0] next_pc; } ret_t;
    typedef struct { logic [63:0] addr; logic [63:0] data; } st_t;

    ret_t        exp_ret_q[$];
    st_t         exp_st_q[$];
    logic [7:0]  exp_len_q[$];

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          n_overlap;
    int          n_halt_req;
    logic        chk_next;
    logic [63:0] exp_next;
    int          dmem_delay;
    logic [31:0] prog [0:31];
    logic [63:0] dmem_mem [0:63];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ret(input int c, input logic [63:0] pc, input logic [63:0] nxt);
        ret_t r;
        r.cyc = c; r.pc = pc; r.next_pc = nxt;
        exp_ret_q.push_back(r);
    endtask

    task automatic push_st(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] len);
        st_t s;
        s.addr = addr; s.data = data;
        exp_st_q.push_back(s);
        exp_len_q.push_back(len);
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 32; i++) prog[i] = HALT_INSN;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_test(input string name);
        reset      = 1'b0;
        chk_next   = 1'b0;
        n_overlap  = 0;
        n_halt_req = 0;
        @(posedge clk); #1;
        check({name, "_rst_state"},   64'(dbg_state), 64'(ST_FETCH));
        check({name, "_rst_pc"},      pc_out, 64'd0);
        check({name, "_rst_imemreq"}, 64'(imem_req), 64'd0);
        check({name, "_rst_dmemreq"}, 64'(dmem_req), 64'd0);
        check({name, "_rst_retire"},  64'(retire), 64'd0);
        check({name, "_rst_halted"},  64'(halted), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while ((exp_ret_q.size() != 0 || exp_st_q.size() != 0) && n < bound) begin
            @(posedge clk);
            n++;
        end
        check({name, "_pending"}, 64'(exp_ret_q.size() + exp_st_q.size()), 64'd0);
        exp_ret_q.delete();
        exp_st_q.delete();
        exp_len_q.delete();
    endtask

    task automatic finish_test(input string name, input logic [63:0] final_pc);
        repeat (6) @(negedge clk);
        check({name, "_halted"},   64'(halted), 64'd1);
        check({name, "_state"},    64'(dbg_state), 64'(ST_HALT));
        check({name, "_final_pc"}, pc_out, final_pc);
        check({name, "_halt_req"}, 64'(n_halt_req), 64'd0);
        check({name, "_overlap"},  64'(n_overlap), 64'd0);
    endtask

    // ---------------- memory responders ----------------
    initial begin
        int dwait;
        dwait      = 0;
        imem_ready = 1'b1;
        imem_rdata = HALT_INSN;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            imem_rdata = prog[imem_addr[4:0]];
            if (dmem_req) begin
                if (dwait >= dmem_delay) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = dmem_mem[dmem_addr[5:0]];
                    if (dmem_we) dmem_mem[dmem_addr[5:0]] = dmem_wdata;
                    dwait = 0;
                end else begin
                    dmem_ready = 1'b0;
                    dwait++;
                end
            end else begin
                dmem_ready = 1'b0;
                dwait      = 0;
            end
        end
    end

    always @(posedge clk) if (reset) cyc++;

    // ---------------- monitor ----------------
    initial begin
        int   cur;
        int   run_len;
        ret_t r;
        st_t  s;
        logic [7:0] len;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cur = cyc + 1;
                if (imem_req && dmem_req) n_overlap++;
                if (halted && imem_req) n_halt_req++;
                if (chk_next) begin
                    chk_next = 1'b0;
                    check("next_pc", pc_out, exp_next);
                end
                if (retire) begin
                    if (exp_ret_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_retire: pc %0h at cycle %0d, none expected", pc_out, cur);
                    end else begin
                        r = exp_ret_q.pop_front();
                        check("retire_cycle", 64'(cur), 64'(r.cyc));
                        check("retire_pc", pc_out, r.pc);
                        exp_next = r.next_pc;
                        chk_next = 1'b1;
                    end
                end
                if (dmem_req) run_len++;
                else run_len = 0;
                if (dmem_req && dmem_ready) begin
                    if (exp_len_q.size() != 0) begin
                        len = exp_len_q.pop_front();
                        check("dmem_req_cycles", 64'(run_len), 64'(len));
                    end
                    if (dmem_we) begin
                        if (exp_st_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_store: addr %0h data %0h, none expected", dmem_addr, dmem_wdata);
                        end else begin
                            s = exp_st_q.pop_front();
                            check("store_addr", dmem_addr, s.addr);
                            check("store_data", dmem_wdata, s.data);
                        end
                    end
                    run_len = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        n_cmp      = 0;
        n_bad      = 0;
        cyc        = 0;
        chk_next   = 1'b0;
        exp_next   = '0;
        n_overlap  = 0;
        n_halt_req = 0;
        dmem_delay = 0;
        reset      = 1'b0;
        for (int i = 0; i < 64; i++) dmem_mem[i] = '0;

        // addi x1,x0,5 ; add x2,x1,x1
        fill_halt();
        prog[0] = 32'h00500093;
        prog[1] = 32'h00108133;
        push_ret(4, 64'd0, 64'd1);
        push_ret(8, 64'd1, 64'd2);
        start_test("t1");
        drain("t1", 40);
        @(negedge clk);
`ifdef MULTICYCLE_CORE_PERF_EN
        check("t1_cycle_cnt", cycle_cnt, 64'd8);
        check("t1_instret_cnt", instret_cnt, 64'd2);
`endif
        finish_test("t1", 64'd2);

        // x2=10 ; sd x2,8(x0) ; ld x3,8(x0) ; sd x3,16(x0), data side waits 3 cycles
        fill_halt();
        prog[0] = 32'h00500093;
        prog[1] = 32'h00108133;
        prog[2] = 32'h00203423;
        prog[3] = 32'h00803183;
        prog[4] = 32'h00303823;
        dmem_delay = 3;
        push_ret(4,  64'd0, 64'd1);
        push_ret(8,  64'd1, 64'd2);
        push_ret(15, 64'd2, 64'd3);
        push_ret(23, 64'd3, 64'd4);
        push_ret(30, 64'd4, 64'd5);
        push_st(64'd8,  64'd10, 8'd4);
        exp_len_q.push_back(8'd4);
        push_st(64'd16, 64'd10, 8'd4);
        start_test("t2");
        drain("t2", 80);
        finish_test("t2", 64'd5);

        // beq x0,x0,+8 at pc 4 after four addi x0,x0,7
        fill_halt();
        for (int i = 0; i < 4; i++) prog[i] = 32'h00700013;
        prog[4] = 32'h00000463;
        dmem_delay = 0;
        push_ret(4,  64'd0, 64'd1);
        push_ret(8,  64'd1, 64'd2);
        push_ret(12, 64'd2, 64'd3);
        push_ret(16, 64'd3, 64'd4);
        push_ret(19, 64'd4, 64'd8);
        start_test("t3a");
        drain("t3a", 40);
        finish_test("t3a", 64'd8);

        // bne x0,x0,+8 at pc 4 falls through
        prog[4] = 32'h00001463;
        push_ret(4,  64'd0, 64'd1);
        push_ret(8,  64'd1, 64'd2);
        push_ret(12, 64'd2, 64'd3);
        push_ret(16, 64'd3, 64'd4);
        push_ret(19, 64'd4, 64'd5);
        start_test("t3b");
        drain("t3b", 40);
        finish_test("t3b", 64'd5);

        // addi x0,x0,7 ; sd x0,16(x0) ; illegal opcode
        fill_halt();
        prog[0] = 32'h00700013;
        prog[1] = 32'h00003823;
        dmem_mem[16] = 64'h5555;
        push_ret(4, 64'd0, 64'd1);
        push_ret(8, 64'd1, 64'd2);
        push_st(64'd16, 64'd0, 8'd1);
        start_test("t4");
        drain("t4", 40);
        finish_test("t4", 64'd2);

        // reset during a load's data wait, then show nothing was written
        fill_halt();
        prog[0] = 32'h00500093;
        prog[1] = 32'h00803183;
        dmem_mem[8] = 64'h1234;
        dmem_delay = 1000;
        push_ret(4, 64'd0, 64'd1);
        start_test("t5");
        n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_mem_reached", 64'(dmem_req), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_async_state",   64'(dbg_state), 64'(ST_FETCH));
        check("t5_async_pc",      pc_out, 64'd0);
        check("t5_async_dmemreq", 64'(dmem_req), 64'd0);
        check("t5_async_imemreq", 64'(imem_req), 64'd0);
        check("t5_async_retire",  64'(retire), 64'd0);
        exp_ret_q.delete();
        fill_halt();
        prog[0] = 32'h00303823;
        prog[1] = 32'h00103c23;
        dmem_delay = 0;
        push_ret(4, 64'd0, 64'd1);
        push_ret(8, 64'd1, 64'd2);
        push_st(64'd16, 64'd0, 8'd1);
        push_st(64'd24, 64'd0, 8'd1);
        start_test("t5b");
        drain("t5b", 40);
        finish_test("t5b", 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter XLEN, default 64: datapath, register, PC and data-address width; legal values are 32 and 64.
REQ-002 Parameter NREGS, default 32: architectural register count; the register index is log2(NREGS) bits, taken from the low bits of the rs1/rs2/rd fields.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imem_req  output  1  instruction fetch request, held high until accepted.
REQ-007 imem_addr  output  XLEN  instruction word index (equals PC).
REQ-008 imem_ready  input  1  fetch accepted; imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 dmem_req  output  1  data access request, held high until accepted.
REQ-011 dmem_we  output  1  1 = store, 0 = load; valid while dmem_req is high.
REQ-012 dmem_addr  output  XLEN  data address (ALU result).
REQ-013 dmem_wdata  output  XLEN  store data (rs2).
REQ-014 dmem_ready  input  1  access accepted; dmem_rdata is valid in the same cycle for loads.
REQ-015 dmem_rdata  input  XLEN  load data.
REQ-016 retire  output  1  one-cycle pulse per completed instruction.
REQ-017 halted  output  1  core is stopped on an illegal instruction.
REQ-018 pc_out  output  XLEN  current PC.

Function
REQ-019 The FSM SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and HALT, with exactly one state active per cycle.
REQ-020 FETCH: imem_req=1; on imem_ready, latch IR and go to DECODE; otherwise stay in FETCH with imem_addr stable.
REQ-021 DECODE: latch A=rs1 and B=rs2, plus the sign-extended immediate in I/S/B format, extended to XLEN.
REQ-022 Supported instructions:
- R-type 0110011: add, sub (funct7=0100000), and, or, slt.
- I-type 0010011: addi, andi, ori.
- 0000011 with funct3=011: ld.
- 0100011 with funct3=011: sd.
- 1100011: beq (funct3=000), bne (funct3=001).
REQ-023 Any other opcode or funct combination SHALL cause DECODE to go to HALT.
REQ-024 EXEC: compute the ALU result in modulo 2^XLEN arithmetic; slt is a signed compare.
- ALU/addi -> WB.
- ld/sd -> MEM.
- Branch: PC <= taken ? PC+sext(imm[12:1]) : PC+1, then FETCH, with retire=1.
REQ-025 Branch offsets and PC increments SHALL be in instruction units; PC wraps modulo 2^XLEN.
REQ-026 MEM: dmem_req=1, with dmem_we, dmem_addr and dmem_wdata stable until dmem_ready.
- On dmem_ready for ld: latch MDR and go to WB.
- On dmem_ready for sd: PC <= PC+1, go to FETCH, retire=1.
REQ-027 WB: rd <= MDR for ld, otherwise rd <= ALU result; PC <= PC+1; retire=1; go to FETCH.
REQ-028 Writes to register 0 SHALL be discarded, and register 0 SHALL always read as 0.
REQ-029 Minimum latency with ready=1 on first request:
- ALU/I-type: 4 cycles.
- ld: 5 cycles.
- sd: 4 cycles.
- Branch: 3 cycles.
Each wait cycle adds exactly 1 cycle.
REQ-030 HALT: halted=1, no requests issued, state held until reset.
REQ-031 imem_req and dmem_req SHALL never be high in the same cycle.

Reset
REQ-032 While reset=0, asynchronously:
- State = FETCH.
- PC = RESET_PC.
- All registers, IR, A, B and MDR = 0.
- retire=0, halted=0, imem_req=0, dmem_req=0.
REQ-033 imem_req SHALL first assert in the first cycle after reset deasserts.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no register or PC update; a late ready response is ignored.

Configuration
REQ-035 Macro MULTICYCLE_CORE_PERF_EN, when defined, adds two outputs, both XLEN wide, reset to 0 and wrapping on overflow:
- cycle_cnt: increments every cycle the core is not in HALT.
- instret_cnt: increments on each retire.
REQ-036 When MULTICYCLE_CORE_PERF_EN is undefined, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-037 Reset, then addi x1,x0,5 followed by add x2,x1,x1 with ready tied high -> x2=10, retire pulses at cycles 4 and 8, pc_out=2.
REQ-038 Store x2 then load: sd x2,8(x0); ld x3,8(x0) with dmem_ready delayed 3 cycles -> x3=10, dmem_req held 4 cycles each, sd latency 7 cycles, ld latency 8 cycles.
REQ-039 beq x0,x0,+8 (imm=8) at PC=4 -> pc_out=8 after 3 cycles; bne x0,x0 -> pc_out=5.
REQ-040 addi x0,x0,7 -> x0 reads 0; opcode 1111111 -> halted=1, no further imem_req.
REQ-041 Reset asserted during a MEM wait -> state=FETCH, PC=RESET_PC, no register write.
REQ-042 With MULTICYCLE_CORE_PERF_EN defined, after REQ-037 -> instret_cnt=2, cycle_cnt=8.
